// File: rtl/bi_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bi_loader_pkg
//  Description : Shared constants and FSM state type for the bias/weight
//                memory loader (coefficient width, lanes per word, states).
//  Revision    : 1.0 - initial release
// ============================================================================
package bi_loader_pkg;

  localparam int COEF_WIDTH = 16;
  localparam int LANES      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bi_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : bi_mem_loader_if
//  Description : Coefficient stream (valid/ready) plus memory write port of
//                the bias/weight loader. The loader is the slave of the
//                stream and drives the write port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bi_mem_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128,
  parameter int COEF_WIDTH = 16
);

  logic                  s_valid;
  logic [COEF_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, wr_en, wr_addr, wr_data
  );

endinterface
`default_nettype wire

// File: rtl/bi_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : bi_word_packer
//  Description : Packs coefficients MSB-lane-first into one memory word.
//                o_word_next is the register contents with the incoming
//                coefficient merged into the current lane, so the caller can
//                capture a completed word in the same cycle as the insert.
//  Revision    : 1.0 - initial release
// ============================================================================
module bi_word_packer
  import bi_loader_pkg::*;
#(
  parameter int COEF_W  = COEF_WIDTH,
  parameter int N_LANES = LANES
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic                        i_clr,
  input  wire logic                        i_ins,
  input  wire logic [COEF_W-1:0]           i_din,
  output logic      [COEF_W*N_LANES-1:0]   o_word_next,
  output logic                             o_full
);

  localparam int DATA_W  = COEF_W * N_LANES;
  localparam int LANE_AW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [LANE_AW-1:0] c_last_lane = LANE_AW'(N_LANES - 1);

  logic [DATA_W-1:0]  r_word;
  logic [LANE_AW-1:0] r_lane;

  // The insert about to happen fills the last lane of the word.
  assign o_full = (r_lane == c_last_lane);

  // Lane l occupies the l-th COEF_W slice counted down from the MSB.
  generate
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
      localparam logic [LANE_AW-1:0] c_idx = LANE_AW'(l);
      assign o_word_next[DATA_W-1-COEF_W*l -: COEF_W] =
        (i_ins && (r_lane == c_idx)) ? i_din : r_word[DATA_W-1-COEF_W*l -: COEF_W];
    end
  endgenerate

  // Lane register: cleared on request or after a full word, else accumulates.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_ins) begin
      if (o_full) begin
        r_word <= '0;
        r_lane <= '0;
      end else begin
        r_word <= o_word_next;
        r_lane <= r_lane + LANE_AW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bi_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bi_mem_loader
//  Description : Streams NUM_COEFS signed coefficients into a bias/weight RAM,
//                packing them MSB-lane-first into DATA_WIDTH words written at
//                consecutive addresses; the last partial word is zero padded.
//                Optional feature macro: BI_MEM_LOADER_CHECKSUM_EN adds a
//                32-bit wrapping sum of the sign-extended coefficients.
//  Revision    : 1.0 - initial release
// ============================================================================
module bi_mem_loader
  import bi_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16,
  parameter int NUM_COEFS  = 122,
  parameter int COEF_WIDTH = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  bi_mem_loader_if.slave   bus,
  output logic             busy,
  output logic             done
`ifdef BI_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      chk_sum
`endif
);

  localparam int NLANES = DATA_WIDTH / COEF_WIDTH;
  localparam int CCW    = $clog2(NUM_COEFS + 1);
  localparam logic [CCW-1:0]        c_last_coef = CCW'(NUM_COEFS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_ready;
  logic                  w_start_ok;
  logic                  w_hs;
  logic                  w_last;
  logic                  w_full;
  logic                  w_emit;
  logic [DATA_WIDTH-1:0] w_word_next;
  logic [CCW-1:0]        r_coef_cnt;
  logic [ADDR_WIDTH-1:0] r_word_cnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  assign w_hs   = bus.s_valid && w_ready;
  assign w_last = (r_coef_cnt == c_last_coef);
  // A word leaves the packer when it fills up or when the stream ends.
  assign w_emit = w_hs && (w_full || w_last);

  bi_word_packer #(
    .COEF_W  (COEF_WIDTH),
    .N_LANES (NLANES)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_start_ok),
    .i_ins       (w_hs),
    .i_din       (bus.s_data),
    .o_word_next (w_word_next),
    .o_full      (w_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: the final handshake always goes through FLUSH.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    if (w_hs && w_last) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; start only counts while idle.
  always_comb begin
    w_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    w_start_ok = 1'b0;
    case (r_state)
      IDLE:  w_start_ok = start;
      LOAD:  begin w_ready = 1'b1; busy = 1'b1; end
      FLUSH: busy = 1'b1;
      DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Counters and registered write port; the write lands the cycle after the
  // handshake that completes the word, and address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_coef_cnt <= '0;
      r_word_cnt <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= w_emit;
      if (w_start_ok) begin
        r_coef_cnt <= '0;
        r_word_cnt <= '0;
      end else if (w_hs) begin
        r_coef_cnt <= r_coef_cnt + CCW'(1);
        if (w_full && !w_last && (r_word_cnt != c_last_addr))
          r_word_cnt <= r_word_cnt + ADDR_WIDTH'(1);
      end
      if (w_emit) begin
        r_wr_addr <= r_word_cnt;
        r_wr_data <= w_word_next;
      end
    end
  end

  assign bus.s_ready = w_ready;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

`ifdef BI_MEM_LOADER_CHECKSUM_EN
  logic [31:0] r_chk_sum;

  // Running wrap-around sum of sign-extended coefficients, held after done.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) r_chk_sum <= '0;
    else if (w_hs)         r_chk_sum <= r_chk_sum + 32'($signed(bus.s_data));
  end

  assign chk_sum = r_chk_sum;
`endif

endmodule
`default_nettype wire
